// File: rtl/render_engine.sv
// Render engine: maps pixel counters to board cells, fetches the board word and
// colours the pixel. Counters to pixel/sync outputs take MEM_LATENCY+2 cycles.
module render_engine #(
    parameter int          WORD_SIZE      = 16,
    parameter int          LOG_BOARD_SIZE = 8,
    parameter int          MEM_LATENCY    = 1,
    parameter int          MAX_LOG_CELL   = 4,
    parameter int          VIEW_PIX       = 768,
    parameter int          SCREEN_HEIGHT  = 768,
    parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
    parameter logic [11:0] GRID_COLOR     = 12'h333,
    localparam int LOG_WORD     = $clog2(WORD_SIZE),
    localparam int LOG_MAX_ADDR = 2 * LOG_BOARD_SIZE - LOG_WORD,
    localparam int ZOOM_W       = $clog2(MAX_LOG_CELL + 1)
) (
    input  logic                      clk_130mhz,
    input  logic                      rst_n_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [LOG_BOARD_SIZE-1:0] view_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] view_y_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic [ZOOM_W-1:0]         zoom_in,
    input  logic                      grid_en_in,
    output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
    output logic                      rd_en_out,
    input  logic [WORD_SIZE-1:0]      data_r_in,
    output logic [11:0]               pix_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      done_out
);
    localparam int LB = LOG_BOARD_SIZE;
    localparam logic [ZOOM_W-1:0] MAX_ZOOM = ZOOM_W'(MAX_LOG_CELL);
    localparam logic [10:0]       VIEW_H   = 11'(VIEW_PIX);
    localparam logic [9:0]        VIEW_V   = 10'(VIEW_PIX);
    localparam logic [9:0]        SCREEN_V = 10'(SCREEN_HEIGHT);

    typedef struct packed {
        logic [LOG_WORD-1:0] bit_sel;
        logic                border;
        logic                grid;
        logic                visible;
        logic                blank;
        logic                hsync;
        logic                vsync;
        logic                done;
    } meta_t;

    logic [LB-1:0]     view_x_q, view_y_q, cursor_x_q, cursor_y_q;
    logic [ZOOM_W-1:0] zoom_q;
    logic              grid_en_q;

    logic              frame_start;
    logic [ZOOM_W-1:0] zoom_clamped;
    assign frame_start  = (hcount_in == '0) && (vcount_in == '0);
    assign zoom_clamped = (zoom_in > MAX_ZOOM) ? MAX_ZOOM : zoom_in;

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            view_x_q   <= '0;
            view_y_q   <= '0;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            zoom_q     <= MAX_ZOOM;
            grid_en_q  <= 1'b0;
        end else if (frame_start) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            view_x_q   <= view_x_in;
            view_y_q   <= view_y_in;
            cursor_x_q <= cursor_x_in;
            cursor_y_q <= cursor_y_in;
            zoom_q     <= zoom_clamped;
            grid_en_q  <= grid_en_in;
        end
    end

    // The capture cycle is itself pixel (0,0), so it renders with the fresh settings.
    logic [LB-1:0]     cur_view_x, cur_view_y, cur_cursor_x, cur_cursor_y;
    logic [ZOOM_W-1:0] cur_zoom;
    logic              cur_grid_en;
    assign cur_view_x   = frame_start ? view_x_in    : view_x_q;
    assign cur_view_y   = frame_start ? view_y_in    : view_y_q;
    assign cur_cursor_x = frame_start ? cursor_x_in  : cursor_x_q;
    assign cur_cursor_y = frame_start ? cursor_y_in  : cursor_y_q;
    assign cur_zoom     = frame_start ? zoom_clamped : zoom_q;
    assign cur_grid_en  = frame_start ? grid_en_in   : grid_en_q;

    logic [LB-1:0]           board_x, board_y;
    logic [10:0]             lo_mask, lo_x, lo_y;
    logic                    on_cursor;
    logic [LOG_MAX_ADDR-1:0] addr_next;
    meta_t                   meta_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        meta_next = '0;
        board_x   = cur_view_x + LB'(hcount_in >> cur_zoom);
        board_y   = cur_view_y + LB'(vcount_in >> cur_zoom);
        lo_mask   = (11'd1 << cur_zoom) - 11'd1;
        lo_x      = hcount_in & lo_mask;
        lo_y      = {1'b0, vcount_in} & lo_mask;
        on_cursor = (board_x == cur_cursor_x) && (board_y == cur_cursor_y);
        addr_next = {board_y, board_x[LB-1:LOG_WORD]};

        meta_next.bit_sel = board_x[LOG_WORD-1:0];
        meta_next.border  = on_cursor && (lo_x == '0 || lo_x == lo_mask ||
                                          lo_y == '0 || lo_y == lo_mask);
        meta_next.grid    = cur_grid_en && (cur_zoom >= ZOOM_W'(2)) &&
                            (lo_x == '0 || lo_y == '0);
        meta_next.visible = (hcount_in < VIEW_H) && (vcount_in < VIEW_V);
        meta_next.blank   = blank_in;
        meta_next.hsync   = hsync_in;
        meta_next.vsync   = vsync_in;
        meta_next.done    = vcount_in >= SCREEN_V;
    end

    // Stage 0 sits beside addr_r_out; stage MEM_LATENCY lines up with data_r_in.
    meta_t meta_q [MEM_LATENCY+1];

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_r_out <= '0;
            rd_en_out  <= 1'b0;
            for (int i = 0; i <= MEM_LATENCY; i++) meta_q[i] <= '0;
        end else begin
            addr_r_out <= addr_next;
            rd_en_out  <= (addr_next != addr_r_out) || (hcount_in == '0 && !blank_in);
            meta_q[0]  <= meta_next;
            for (int i = 1; i <= MEM_LATENCY; i++) meta_q[i] <= meta_q[i-1];
        end
    end

    meta_t               tail;
    logic [LOG_WORD-1:0] bit_idx;
    logic [11:0]         pix_next;
    assign tail    = meta_q[MEM_LATENCY];
    assign bit_idx = ~tail.bit_sel;  // x-offset 0 lives in the MSB

    always_comb begin
        pix_next = 12'h000;
        if (tail.blank || !tail.visible) pix_next = 12'h000;
        else if (tail.border)            pix_next = 12'hFFF;
        else if (tail.grid)              pix_next = GRID_COLOR;
        else if (data_r_in[bit_idx])     pix_next = ALIVE_COLOR;
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_out   <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            done_out  <= 1'b1;
        end else begin
            pix_out   <= pix_next;
            hsync_out <= ~tail.hsync;
            vsync_out <= ~tail.vsync;
            done_out  <= tail.done;
        end
    end
endmodule

// File: tb/tb_render_engine.sv
// Directed bench for render_engine: one default instance and one with a
// three-cycle memory and distinct alive colour, both fed the same counters.
module tb_render_engine;
    localparam int LOGN = 8192;

    logic clk_130mhz = 1'b0;
    always #4 clk_130mhz = ~clk_130mhz;

    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic [7:0]  view_x_in, view_y_in, cursor_x_in, cursor_y_in;
    logic [2:0]  zoom_in;
    logic        grid_en_in;

    logic [11:0] addr1, addr3, pix1, pix3;
    logic        rd1, rd3, hs1, hs3, vs1, vs3, done1, done3;
    logic [15:0] data1, data3, r3a, r3b;

    render_engine u_dut (
        .clk_130mhz(clk_130mhz), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .view_x_in(view_x_in), .view_y_in(view_y_in),
        .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
        .zoom_in(zoom_in), .grid_en_in(grid_en_in),
        .addr_r_out(addr1), .rd_en_out(rd1), .data_r_in(data1),
        .pix_out(pix1), .hsync_out(hs1), .vsync_out(vs1), .done_out(done1)
    );

    render_engine #(.MEM_LATENCY(3), .ALIVE_COLOR(12'h0F0)) u_dut3 (
        .clk_130mhz(clk_130mhz), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .view_x_in(view_x_in), .view_y_in(view_y_in),
        .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
        .zoom_in(zoom_in), .grid_en_in(grid_en_in),
        .addr_r_out(addr3), .rd_en_out(rd3), .data_r_in(data3),
        .pix_out(pix3), .hsync_out(hs3), .vsync_out(vs3), .done_out(done3)
    );

    // Board memory: one-cycle read for u_dut, three-cycle read for u_dut3.
    logic [15:0] board [4096];
    always @(posedge clk_130mhz) begin
        data1 <= board[addr1];
        r3a   <= board[addr3];
        r3b   <= r3a;
        data3 <= r3b;
    end

    int cyc = 0;
    always @(posedge clk_130mhz) cyc <= cyc + 1;

    logic [11:0] pix1_log [LOGN];
    logic [11:0] pix3_log [LOGN];
    logic [11:0] addr_log [LOGN];
    logic        rd_log   [LOGN];
    logic        hs1_log  [LOGN];
    logic        hs3_log  [LOGN];
    logic        vs1_log  [LOGN];
    logic        done_log [LOGN];
    always @(negedge clk_130mhz) begin
        pix1_log[cyc % LOGN] <= pix1;
        pix3_log[cyc % LOGN] <= pix3;
        addr_log[cyc % LOGN] <= addr1;
        rd_log[cyc % LOGN]   <= rd1;
        hs1_log[cyc % LOGN]  <= hs1;
        hs3_log[cyc % LOGN]  <= hs3;
        vs1_log[cyc % LOGN]  <= vs1;
        done_log[cyc % LOGN] <= done1;
    end

    int errors = 0;
    int checks = 0;
    int hc [2048];
    int ca, cd, ce, dummy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one sample; c is the cycle count at drive time, so the default
    // instance shows the pixel at log index c+3 and the address at c+1.
    task automatic step(input int h, input int v, input logic b, input logic hs,
                        input logic vs, output int c);
        @(negedge clk_130mhz);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        blank_in  = b;
        hsync_in  = hs;
        vsync_in  = vs;
        c = cyc;
        @(posedge clk_130mhz);
        #1;
    endtask

    task automatic line(input int v, input int h0, input int h1, input logic b);
        for (int h = h0; h <= h1; h++) step(h, v, b, 1'b0, 1'b0, hc[h]);
        for (int i = 0; i < 6; i++) step(1200, 800, 1'b1, 1'b0, 1'b0, dummy);
    endtask

    task automatic config_set(input logic [7:0] vx, input logic [7:0] vy, input logic [7:0] cx,
                              input logic [7:0] cy, input logic [2:0] z, input logic g);
        view_x_in = vx; view_y_in = vy; cursor_x_in = cx; cursor_y_in = cy;
        zoom_in = z; grid_en_in = g;
    endtask

    function automatic logic [11:0] p1(input int h); return pix1_log[(hc[h] + 3) % LOGN]; endfunction
    function automatic logic [11:0] p3(input int h); return pix3_log[(hc[h] + 5) % LOGN]; endfunction
    function automatic logic        rdh(input int h); return rd_log[(hc[h] + 1) % LOGN]; endfunction
    function automatic logic [11:0] adh(input int h); return addr_log[(hc[h] + 1) % LOGN]; endfunction

    initial begin
        for (int i = 0; i < 4096; i++) board[i] = 16'h0000;
        board[0]  = 16'h8000;  // cell (0,0)
        board[16] = 16'h3000;  // cells (2,1) and (3,1)
        rst_n_in = 1'b0;
        hcount_in = 11'd1200; vcount_in = 10'd800;
        blank_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd4, 1'b0);

        repeat (3) @(posedge clk_130mhz);
        #1;
        check("rst_pix", pix1, 12'h000);
        check("rst_addr", addr1, 12'h000);
        check("rst_rd", rd1, 1'b0);
        check("rst_done", done1, 1'b1);
        check("rst_hsync", hs1, 1'b1);
        check("rst_vsync", vs1, 1'b1);
        @(negedge clk_130mhz);
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) step(1200, 800, 1'b1, 1'b0, 1'b0, dummy);

        // Alignment: cell (0,0) alive at zoom 4 lights h=0..15 on lines 0..15.
        line(0, 0, 20, 1'b0);
        check("align_early", pix1_log[(hc[0] + 2) % LOGN], 12'h000);
        check("align_h0", p1(0), 12'hFFF);
        check("align_h15", p1(15), 12'hFFF);
        check("align_h16", p1(16), 12'h000);
        check("align_rd_first", rdh(0), 1'b1);
        check("align_rd_same", rdh(1), 1'b0);
        check("align_addr0", adh(0), 12'h000);
        line(15, 0, 16, 1'b0);
        check("align_v15_h15", p1(15), 12'hFFF);
        check("align_v15_h16", p1(16), 12'h000);
        line(16, 0, 0, 1'b0);
        check("align_v16_h0", p1(0), 12'h000);

        // Latency: lit pixel and hsync edge emerge together on both instances.
        step(1200, 1, 1'b1, 1'b0, 1'b0, dummy);
        step(0, 1, 1'b0, 1'b1, 1'b0, ca);
        step(1, 1, 1'b0, 1'b1, 1'b0, dummy);
        step(0, 768, 1'b1, 1'b0, 1'b1, cd);
        step(0, 767, 1'b1, 1'b0, 1'b0, ce);
        for (int i = 0; i < 6; i++) step(1200, 800, 1'b1, 1'b0, 1'b0, dummy);
        check("lat1_pix_before", pix1_log[(ca + 2) % LOGN], 12'h000);
        check("lat1_hs_before", hs1_log[(ca + 2) % LOGN], 1'b1);
        check("lat1_pix", pix1_log[(ca + 3) % LOGN], 12'hFFF);
        check("lat1_hs", hs1_log[(ca + 3) % LOGN], 1'b0);
        check("lat3_pix_before", pix3_log[(ca + 4) % LOGN], 12'h000);
        check("lat3_hs_before", hs3_log[(ca + 4) % LOGN], 1'b1);
        check("lat3_pix", pix3_log[(ca + 5) % LOGN], 12'h0F0);
        check("lat3_hs", hs3_log[(ca + 5) % LOGN], 1'b0);
        check("done_768", done_log[(cd + 3) % LOGN], 1'b1);
        check("vsync_768", vs1_log[(cd + 3) % LOGN], 1'b0);
        check("done_767", done_log[(ce + 3) % LOGN], 1'b0);
        check("vsync_767", vs1_log[(ce + 3) % LOGN], 1'b1);

        // Toroidal wrap: view_x=255 puts board cell 0 at pixels 16..31.
        config_set(8'd255, 8'd0, 8'd100, 8'd100, 3'd4, 1'b0);
        line(0, 0, 40, 1'b0);
        check("wrap_h15", p1(15), 12'h000);
        check("wrap_h16", p1(16), 12'hFFF);
        check("wrap_h31", p1(31), 12'hFFF);
        check("wrap_h32", p1(32), 12'h000);
        check("wrap_addr_h0", adh(0), 12'd15);
        check("wrap_addr_h16", adh(16), 12'd0);
        check("wrap_rd_h0", rdh(0), 1'b1);
        check("wrap_rd_h15", rdh(15), 1'b0);
        check("wrap_rd_h16", rdh(16), 1'b1);
        check("wrap_rd_h17", rdh(17), 1'b0);

        // Frame sampling: mid-frame changes are ignored until the next (0,0).
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd4, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, hc[0]);
        config_set(8'd5, 8'd0, 8'd100, 8'd100, 3'd2, 1'b0);
        line(0, 1, 20, 1'b0);
        check("samp_h1", p1(1), 12'hFFF);
        check("samp_h15", p1(15), 12'hFFF);
        check("samp_h16", p1(16), 12'h000);
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd2, 1'b0);
        line(0, 0, 8, 1'b0);
        check("zoom2_h3", p1(3), 12'hFFF);
        check("zoom2_h4", p1(4), 12'h000);
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd7, 1'b0);
        line(0, 0, 20, 1'b0);
        check("zoom7_h15", p1(15), 12'hFFF);
        check("zoom7_h16", p1(16), 12'h000);

        // Grid only from zoom 2 upward.
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd1, 1'b1);
        line(0, 0, 4, 1'b0);
        check("grid_z1_h0", p1(0), 12'hFFF);
        check("grid_z1_h2", p1(2), 12'h000);
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd2, 1'b1);
        line(0, 0, 0, 1'b0);
        line(1, 1, 5, 1'b0);
        check("grid_z2_h1", p1(1), 12'hFFF);
        check("grid_z2_h4", p1(4), 12'h333);
        check("grid_z2_h5", p1(5), 12'h000);

        // Zoom 0: the cursor border is the single cursor pixel.
        config_set(8'd0, 8'd0, 8'd5, 8'd3, 3'd0, 1'b0);
        line(0, 0, 0, 1'b0);
        line(3, 4, 6, 1'b0);
        check("z0_cursor", p1(5), 12'hFFF);
        check("z0_left", p1(4), 12'h000);
        check("z0_right", p1(6), 12'h000);

        // Priority at zoom 3: cursor on alive cell (2,1), grid on.
        config_set(8'd0, 8'd0, 8'd2, 8'd1, 3'd3, 1'b1);
        line(0, 0, 0, 1'b0);
        line(8, 16, 24, 1'b0);
        check("prio_top_border", p3(20), 12'hFFF);
        line(9, 16, 25, 1'b0);
        check("prio_left_border", p3(16), 12'hFFF);
        check("prio_interior", p3(20), 12'h0F0);
        check("prio_interior_d1", p1(20), 12'hFFF);
        check("prio_right_border", p3(23), 12'hFFF);
        check("prio_grid_alive", p3(24), 12'h333);
        check("prio_alive", p3(25), 12'h0F0);
        line(9, 40, 41, 1'b0);
        check("prio_grid_dead", p1(40), 12'h333);
        check("prio_dead", p1(41), 12'h000);
        line(9, 25, 25, 1'b1);
        check("prio_blank_d1", p1(25), 12'h000);
        check("prio_blank_d3", p3(25), 12'h000);

        // Outside the view window the pixel is black even on an alive cell.
        config_set(8'd208, 8'd0, 8'd100, 8'd100, 3'd4, 1'b0);
        line(0, 0, 0, 1'b0);
        line(0, 770, 770, 1'b0);
        check("outside_view", p1(770), 12'h000);

        // Mid-frame reset at vcount=300, then recovery.
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd2, 1'b0);
        line(0, 0, 0, 1'b0);
        for (int h = 0; h <= 10; h++) step(h, 300, 1'b0, 1'b1, 1'b0, dummy);
        check("pre_rst_hsync", hs1, 1'b0);
        check("pre_rst_done", done1, 1'b0);
        #1;
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_pix", pix1, 12'h000);
        check("mid_rst_addr", addr1, 12'h000);
        check("mid_rst_rd", rd1, 1'b0);
        check("mid_rst_done", done1, 1'b1);
        check("mid_rst_hsync", hs1, 1'b1);
        check("mid_rst_vsync", vs1, 1'b1);
        repeat (2) @(posedge clk_130mhz);
        @(negedge clk_130mhz);
        rst_n_in = 1'b1;
        config_set(8'd0, 8'd0, 8'd100, 8'd100, 3'd4, 1'b0);
        step(1, 0, 1'b0, 1'b0, 1'b0, hc[1]);
        step(5, 5, 1'b0, 1'b0, 1'b0, hc[5]);
        for (int i = 0; i < 6; i++) step(1200, 800, 1'b1, 1'b0, 1'b0, dummy);
        check("post_rst_cursor", p3(1), 12'hFFF);
        check("post_rst_zoom", p3(5), 12'h0F0);
        line(0, 0, 16, 1'b0);
        check("post_frame_h0", p1(0), 12'hFFF);
        check("post_frame_h15_d3", p3(15), 12'h0F0);
        check("post_frame_h16", p1(16), 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
